// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; accept-to-tx_done is 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
// tx_start is honoured only while tx_ready (IDLE) is high; UART_TX_PARITY_EN adds a parity bit before the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY_BIT = 3'd3,
`endif
    TX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_count_q, clk_count_d;
  logic [2:0]    bit_index_q, bit_index_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_serial_d;
  logic          cnt_end;

  assign cnt_end = (clk_count_q == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^tx_data_q) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_index_q <= '0;
      tx_data_q   <= '0;
      tx_serial   <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      tx_data_q   <= tx_data_d;
      tx_serial   <= tx_serial_d;
    end
  end

  // tx_serial_d is the line level for the state being entered, so the output register needs no decode after it
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    tx_data_d   = tx_data_q;
    tx_serial_d = 1'b1;
    case (state_q)
      IDLE: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (tx_start) begin
          tx_data_d   = tx_byte;
          state_d     = TX_START_BIT;
          tx_serial_d = 1'b0;
        end
      end
      TX_START_BIT: begin
        tx_serial_d = 1'b0;
        if (cnt_end) begin
          clk_count_d = '0;
          state_d     = TX_DATA_BITS;
          tx_serial_d = tx_data_q[0];
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
      TX_DATA_BITS: begin
        tx_serial_d = tx_data_q[bit_index_q];
        if (cnt_end) begin
          clk_count_d = '0;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d     = TX_PARITY_BIT;
            tx_serial_d = parity_bit;
`else
            state_d     = TX_STOP_BIT;
            tx_serial_d = 1'b1;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
            tx_serial_d = tx_data_q[bit_index_q + 3'd1];
          end
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        tx_serial_d = parity_bit;
        if (cnt_end) begin
          clk_count_d = '0;
          state_d     = TX_STOP_BIT;
          tx_serial_d = 1'b1;
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
`endif
      TX_STOP_BIT: begin
        if (cnt_end) begin
          clk_count_d = '0;
          state_d     = CLEANUP;
        end else begin
          clk_count_d = clk_count_q + CW'(1);
        end
      end
      CLEANUP: begin
        clk_count_d = '0;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  always_comb begin
    tx_ready  = (state_q == IDLE);
    tx_done   = (state_q == CLEANUP);
    tx_active = (state_q == TX_START_BIT) || (state_q == TX_DATA_BITS) ||
                (state_q == TX_STOP_BIT);
`ifdef UART_TX_PARITY_EN
    if (state_q == TX_PARITY_BIT) tx_active = 1'b1;
`endif
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: framing table, then busy-ignore, held-start and reset-abort sequences.
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int TB_PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_serial, tx_active, tx_done;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(TB_PARITY_ODD)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame: start, d0..d7, stop in line order (MSB = first bit on the wire)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par_even;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int j);
    if (j <= 8) return v.frame[9 - j];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return v.par_even ^ TB_PARITY_ODD[0];
`endif
    return v.frame[0];
  endfunction

  // Call just after a negedge; returns just after the negedge of cycle NB*CPB+2.
  task automatic send(input vec_t v, input string name, input bit hold,
                      input int inj_cycle, input logic [7:0] inj_byte, output int acc_cyc);
    int wait_n;
    logic [NB-1:0] bad;
    int done_n, done_at;
    logic act_ok;
    wait_n = 0;
    while (!tx_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, "_ready_wait"}, tx_ready, 1);
    tx_start = 1'b1;
    tx_byte  = v.data;
    @(posedge clk);
    #1 acc_cyc = cyc;
    bad = '0; done_n = 0; done_at = -1; act_ok = 1'b1;
    for (int c = 1; c <= NB*CPB + 1; c++) begin
      @(negedge clk);
      if (c <= NB*CPB) begin
        if (tx_serial !== exp_bit(v, (c-1)/CPB)) bad[(c-1)/CPB] = 1'b1;
        if (tx_active !== 1'b1) act_ok = 1'b0;
      end
      if (tx_done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      if (c == NB*CPB + 1) begin
        check({name, "_ready_at_done"}, tx_ready, 0);
        check({name, "_active_at_done"}, tx_active, 0);
        check({name, "_serial_at_done"}, tx_serial, 1);
      end
      if (c == 1) begin
        if (hold) tx_byte = inj_byte;
        else tx_start = 1'b0;
      end
      if (c == inj_cycle) begin
        tx_start = 1'b1;
        tx_byte  = inj_byte;
      end
      if (c == inj_cycle + 1 && !hold) tx_start = 1'b0;
    end
    @(negedge clk);
    check({name, "_ready_after"}, tx_ready, 1);
    check({name, "_done_after"}, tx_done, 0);
    for (int j = 0; j < NB; j++)
      check($sformatf("%s_bit%0d_bad", name, j), bad[j], 0);
    check({name, "_done_count"}, done_n, 1);
    check({name, "_done_cycle"}, done_at, NB*CPB + 1);
    check({name, "_active_frame"}, act_ok, 1);
  endtask

  task automatic abort_test(input int at_cycle, input string name);
    int done_n;
    int wait_n;
    logic stay_ok;
    wait_n = 0;
    while (!tx_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    tx_start = 1'b1;
    tx_byte  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    done_n = 0;
    for (int c = 2; c <= at_cycle; c++) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_n++;
    end
    #1 reset = 1'b1;
    #1;
    check({name, "_serial_async"}, tx_serial, 1);
    check({name, "_active_async"}, tx_active, 0);
    check({name, "_ready_async"}, tx_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stay_ok = 1'b1;
    for (int c = 0; c < NB*CPB + 4; c++) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_n++;
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) stay_ok = 1'b0;
    end
    check({name, "_no_done"}, done_n, 0);
    check({name, "_idle_after"}, stay_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, dummy;
    logic ok;
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h55, 10'b0101010101, 1'b0};
    vecs[5] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[6] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[7] = '{8'hAA, 10'b0010101011, 1'b0};
    vecs[8] = '{8'h12, 10'b0010010001, 1'b0};

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0)
        ok = 1'b0;
    end
    check("idle_stable_20", ok, 1);

    for (int i = 0; i < 6; i++)
      send(vecs[i], $sformatf("vec%0d_%02h", i, vecs[i].data), 1'b0, 0, 8'h00, dummy);

    // 0x3C requested during data bit 3 of 0x81
    send(vecs[6], "busy_81", 1'b0, 4*CPB + 2, 8'h3C, dummy);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) ok = 1'b0;
    end
    check("busy_no_queued_frame", ok, 1);

    // tx_start held high across two frames; tx_byte changes mid-frame
    send(vecs[4], "held_55", 1'b1, 0, vecs[7].data, a1);
    send(vecs[7], "held_aa", 1'b1, 0, 8'h00, a2);
    tx_start = 1'b0;
    check("held_spacing", a2 - a1, NB*CPB + 2);
    repeat (4) @(negedge clk);

    abort_test(2, "abort_start");
    abort_test(26, "abort_bit5");
    send(vecs[8], "after_abort_12", 1'b0, 0, 8'h00, dummy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
